// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer: buffers A columns and streams them to the array with row r delayed r cycles.
// Optional SKEW_REPLAY_EN keeps the buffered columns after a pass and adds clear_i.
module systolic_input_skewer #(
  parameter int ROWS   = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ld_valid_i,
  output logic                        ld_ready_o,
  input  logic [ROWS*DATA_W-1:0]      ld_data_i,
  input  logic                        start_i,
  input  logic                        hold_i,
`ifdef SKEW_REPLAY_EN
  input  logic                        clear_i,
`endif
  output logic [ROWS*DATA_W-1:0]      a_out_o,
  output logic [ROWS-1:0]             a_valid_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + ROWS);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_ld, ce;
  logic [TW-1:0] t_q, t_d, ts;
  logic [ROWS*DATA_W-1:0] a_out_q, a_out_d, step_data;
  logic [ROWS-1:0] a_valid_q, a_valid_d, step_valid;
  logic done_q, done_d, fire, clr;
  logic [AW-1:0] wr_addr;
  logic [ROWS*DATA_W-1:0] mem_q [DEPTH];
`ifdef SKEW_REPLAY_EN
  assign clr = clear_i && state_q == IDLE;
`else
  assign clr = 1'b0;
`endif
  assign ld_ready_o = state_q == IDLE && count_q < CW'(DEPTH);
  assign fire       = ld_valid_i && ld_ready_o;
  assign wr_addr    = clr ? '0 : AW'(count_q);
  assign count_ld   = clr ? CW'(fire) : count_q + CW'(fire);
  // Step 0 is produced on the start edge, so a beat loaded that same cycle is bypassed in.
  assign ts = state_q == IDLE ? '0 : t_q;
  assign ce = state_q == IDLE ? count_ld : count_q;
  always_comb begin
    step_data  = '0;
    step_valid = '0;
    for (int r = 0; r < ROWS; r++)
      if (int'(ts) - r >= 0 && int'(ts) - r < int'(ce)) begin
        step_valid[r] = 1'b1;
        step_data[r*DATA_W +: DATA_W] = (fire && AW'(int'(ts) - r) == wr_addr) ?
          ld_data_i[r*DATA_W +: DATA_W] : mem_q[AW'(int'(ts) - r)][r*DATA_W +: DATA_W];
      end
  end
  // t_q always points one past the step currently on the outputs.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    t_d       = t_q;
    a_out_d   = a_out_q;
    a_valid_d = a_valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = count_ld;
        if (start_i && count_ld != '0) begin
          state_d   = STREAM;
          t_d       = TW'(1);
          a_out_d   = step_data;
          a_valid_d = step_valid;
        end else if (start_i) done_d = 1'b1;
      end
      STREAM: if (!hold_i) begin
        if (int'(t_q) == int'(count_q) + ROWS - 1) begin
          state_d   = DONE;
          a_out_d   = '0;
          a_valid_d = '0;
          done_d    = 1'b1;
`ifndef SKEW_REPLAY_EN
          count_d   = '0;
`endif
        end else begin
          t_d       = t_q + 1'b1;
          a_out_d   = step_data;
          a_valid_d = step_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      t_q       <= '0;
      a_out_q   <= '0;
      a_valid_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      t_q       <= t_d;
      a_out_q   <= a_out_d;
      a_valid_q <= a_valid_d;
      done_q    <= done_d;
    end
  always_ff @(posedge clk_i)
    if (fire) mem_q[wr_addr] <= ld_data_i;
  assign a_out_o   = a_out_q;
  assign a_valid_o = a_valid_q;
  assign busy_o    = state_q == STREAM;
  assign done_o    = done_q;
  assign count_o   = count_q;
endmodule

// File: tb/tb_systolic_input_skewer.sv
// tb_systolic_input_skewer: ROWS=2 and ROWS=4 instances share stimulus; each is checked every cycle
// against a model that derives each visible step from the buffered column list.
module tb_systolic_input_skewer;
  localparam int DW = 16, DEPTH = 8;
  logic clk = 0, rst_n = 0, ld_valid = 0, start = 0, hold = 0;
`ifdef SKEW_REPLAY_EN
  logic clear = 0;
`endif
  logic [63:0] ld_data = '0;
  logic [31:0] a_out2;
  logic [63:0] a_out4;
  logic [1:0] a_valid2;
  logic [3:0] a_valid4;
  logic rdy2, rdy4, busy2, busy4, done2, done4;
  logic [3:0] cnt2, cnt4;
  int n_chk = 0, n_err = 0;
  logic [63:0] mcol [2][DEPTH];
  int mcnt [2], mst [2], midx [2], mdone [2];
  int obs_busy [2], obs_done [2];
  always #5 clk = ~clk;
  systolic_input_skewer #(.ROWS(2), .DATA_W(DW), .DEPTH(DEPTH)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(rdy2), .ld_data_i(ld_data[31:0]),
    .start_i(start), .hold_i(hold),
`ifdef SKEW_REPLAY_EN
    .clear_i(clear),
`endif
    .a_out_o(a_out2), .a_valid_o(a_valid2), .busy_o(busy2), .done_o(done2), .count_o(cnt2));
  systolic_input_skewer #(.ROWS(4), .DATA_W(DW), .DEPTH(DEPTH)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(rdy4), .ld_data_i(ld_data),
    .start_i(start), .hold_i(hold),
`ifdef SKEW_REPLAY_EN
    .clear_i(clear),
`endif
    .a_out_o(a_out4), .a_valid_o(a_valid4), .busy_o(busy4), .done_o(done4), .count_o(cnt4));
  function automatic int rows(input int i);
    return i == 0 ? 2 : 4;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mst[i] = 0; midx[i] = 0; mdone[i] = 0;
    end
  endtask
  // 0 idle, 1 streaming (midx = visible step), 2 done cycle
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      mdone[i] = 0;
      if (mst[i] == 0) begin
        automatic bit rdy = mcnt[i] < DEPTH;
`ifdef SKEW_REPLAY_EN
        if (clear) mcnt[i] = 0;
`endif
        if (ld_valid && rdy) begin
          mcol[i][mcnt[i]] = ld_data;
          mcnt[i]++;
        end
        if (start) begin
          if (mcnt[i] > 0) begin mst[i] = 1; midx[i] = 0; end
          else mdone[i] = 1;
        end
      end else if (mst[i] == 1) begin
        if (!hold) begin
          if (midx[i] == mcnt[i] + rows(i) - 2) begin
            mst[i] = 2;
            mdone[i] = 1;
`ifndef SKEW_REPLAY_EN
            mcnt[i] = 0;
`endif
          end else midx[i]++;
        end
      end else mst[i] = 0;
    end
  endtask
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      automatic logic [63:0] ev = '0;
      automatic logic [3:0] vv = '0;
      automatic string p = i == 0 ? "u2." : "u4.";
      if (mst[i] == 1)
        for (int r = 0; r < rows(i); r++) begin
          automatic int k = midx[i] - r;
          if (k >= 0 && k < mcnt[i]) begin
            ev[r*16 +: 16] = mcol[i][k][r*16 +: 16];
            vv[r] = 1'b1;
          end
        end
      chk({p, "a_out"}, i == 0 ? 64'(a_out2) : a_out4, ev);
      chk({p, "a_valid"}, i == 0 ? 64'(a_valid2) : 64'(a_valid4), 64'(vv));
      chk({p, "busy"}, 64'(i == 0 ? busy2 : busy4), 64'(mst[i] == 1));
      chk({p, "done"}, 64'(i == 0 ? done2 : done4), 64'(mdone[i]));
      chk({p, "count"}, 64'(i == 0 ? cnt2 : cnt4), 64'(mcnt[i]));
      chk({p, "ld_ready"}, 64'(i == 0 ? rdy2 : rdy4), 64'(mst[i] == 0 && mcnt[i] < DEPTH));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare();
    if (busy2) obs_busy[0]++;
    if (busy4) obs_busy[1]++;
    if (done2) obs_done[0]++;
    if (done4) obs_done[1]++;
  endtask
  task automatic clr_obs();
    obs_busy[0] = 0; obs_busy[1] = 0; obs_done[0] = 0; obs_done[1] = 0;
  endtask
  task automatic load(input logic [63:0] d);
    ld_valid = 1; ld_data = d;
    tick();
    ld_valid = 0;
  endtask
  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic finish_pass();
    int g = 0;
    while ((busy2 || busy4 || done2 || done4) && g < 60) begin
      tick();
      g++;
    end
    chk("pass_timeout", 64'(g < 60), 64'(1));
    tick();
  endtask
  function automatic logic [63:0] col(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction
  initial begin
    model_reset();
    #1 compare();
    repeat (2) tick();
    rst_n = 1;
    tick();
    // two-column pass on the 2-row array
    load(col(11, 21, 31, 41));
    load(col(12, 22, 32, 42));
    go();
    chk("tp1_step0", 64'(a_out2), 64'({16'd0, 16'd11}));
    chk("tp1_v0", 64'(a_valid2), 64'(2'b01));
    tick();
    chk("tp1_step1", 64'(a_out2), 64'({16'd21, 16'd12}));
    tick();
    chk("tp1_step2", 64'(a_out2), 64'({16'd22, 16'd0}));
    chk("tp1_v2", 64'(a_valid2), 64'(2'b10));
    tick();
    chk("tp1_done", 64'(done2), 64'(1));
    chk("tp1_zero", 64'(a_out2), 64'(0));
    finish_pass();
    // full buffer: ninth beat refused, then an 11-cycle pass on the 4-row array
    for (int j = 0; j < DEPTH; j++) load({$urandom, $urandom});
    chk("full_ready", 64'(rdy4), 64'(0));
    ld_valid = 1; ld_data = {$urandom, $urandom};
    tick();
    clr_obs();
    start = 1;
    tick();
    start = 0; ld_valid = 0;
    finish_pass();
    chk("full_busy4", 64'(obs_busy[1]), 64'(11));
    chk("full_busy2", 64'(obs_busy[0]), 64'(9));
    // hold three cycles while step 1 is visible
    load(col(5, 6, 7, 8));
    load(col(9, 10, 11, 12));
    clr_obs();
    go();
    tick();
    hold = 1;
    repeat (3) tick();
    hold = 0;
    finish_pass();
    chk("hold_busy2", 64'(obs_busy[0]), 64'(6));
    chk("hold_busy4", 64'(obs_busy[1]), 64'(8));
    // empty start
    clr_obs();
    go();
    chk("empty_done", 64'(done2), 64'(1));
    tick();
    chk("empty_busy", 64'(obs_busy[0] + obs_busy[1]), 64'(0));
    // start held during the stream is ignored
    load(col(1, 2, 3, 4));
    clr_obs();
    start = 1;
    repeat (3) tick();
    start = 0;
    finish_pass();
    chk("restart_done2", 64'(obs_done[0]), 64'(1));
    chk("restart_done4", 64'(obs_done[1]), 64'(1));
    // asynchronous reset at step 1
    load(col(100, 200, 300, 400));
    load(col(101, 201, 301, 401));
    go();
    tick();
    rst_n = 0;
    model_reset();
    #1 compare();
    chk("rst_count", 64'(cnt2), 64'(0));
    #2 rst_n = 1;
    load(col(7, 7, 7, 7));
    go();
    finish_pass();
`ifdef SKEW_REPLAY_EN
    load(col(3, 4, 5, 6));
    go();
    finish_pass();
    chk("replay_cnt", 64'(cnt2), 64'(2));
    go();
    finish_pass();
    chk("replay_cnt2", 64'(cnt2), 64'(2));
    clear = 1;
    tick();
    clear = 0;
    chk("clear_cnt", 64'(cnt2), 64'(0));
`endif
    // random traffic
    for (int c = 0; c < 800; c++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data = {$urandom, $urandom};
      start = $urandom_range(0, 9) == 0;
      hold = $urandom_range(0, 3) == 0;
`ifdef SKEW_REPLAY_EN
      clear = $urandom_range(0, 15) == 0;
`endif
      tick();
    end
    ld_valid = 0; start = 0; hold = 0;
`ifdef SKEW_REPLAY_EN
    clear = 0;
`endif
    finish_pass();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
